veritune_buf_ctrl: RTL and testbench

Sample-buffer controller for the Veritune record/playback path. It sits between the mode state machine and the sample RAM. In record mode it writes incoming audio samples at consecutive addresses. In play mode it reads them back through a fixed-point phase accumulator stepped by `Freq`, which produces the pitch-shifted output stream on `Audio_Out`. It owns the RAM address, write, and read strobes, and reports the recorded length.

---
 rtl/veritune_buf_ctrl_if.sv | 28 ++
 rtl/veritune_buf_ctrl.sv | 152 +++++++++++++++
 tb/tb_veritune_buf_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/veritune_buf_ctrl_if.sv
// rtl/veritune_buf_ctrl_if.sv - sample RAM port bundle between buffer controller and RAM
interface veritune_buf_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 1
);
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_WE;
  logic [DATA_W-1:0] Mem_WData;
  logic              Mem_RE;
  logic [DATA_W-1:0] Mem_RData;

  // controller side drives address/strobes, RAM returns read data
  modport master (
    output Mem_Addr,
    output Mem_WE,
    output Mem_WData,
    output Mem_RE,
    input  Mem_RData
  );

  modport slave (
    input  Mem_Addr,
    input  Mem_WE,
    input  Mem_WData,
    input  Mem_RE,
    output Mem_RData
  );
endinterface

// File: rtl/veritune_buf_ctrl.sv
// rtl/veritune_buf_ctrl.sv - record/playback sample-buffer controller with phase-accumulator pitch shift
module veritune_buf_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Rec_Mode,
  input  logic                Play_Mode,
  input  logic                Sample_Tick,
  input  logic [7:0]          Freq,
  input  logic [DATA_W-1:0]   Audio_In,
  veritune_buf_ctrl_if.master mem,
  output logic [DATA_W-1:0]   Audio_Out,
  output logic [ADDR_W:0]     Length,
  output logic                Buf_Full,
  output logic [1:0]          State
);

  // phase: ADDR_W+2 integer bits above 7 fraction bits; it always stays below Length<<7
  localparam int PH_W = ADDR_W + 9;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_HOLD   = 2'd2,
    ST_PLAY   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   length_q, length_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              re_q, re_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] audio_q, audio_d;

  logic              enter_rec;
  logic              enter_play;
  logic [PH_W-1:0]   len_ph;
  logic [PH_W-1:0]   ph_step;
  logic [PH_W-1:0]   ph_wrap1;
  logic [PH_W-1:0]   ph_wrap2;

  // mode inputs pick the next state; record beats play, losing both parks in HOLD
  always_comb begin
    state_d = state_q;
    if (Rec_Mode) begin
      state_d = ST_RECORD;
    end else if (Play_Mode) begin
      state_d = ST_PLAY;
    end else if (state_q == ST_RECORD || state_q == ST_PLAY) begin
      state_d = ST_HOLD;
    end
  end

  // datapath: ticks are handled under the current state, state entry resets pointers
  always_comb begin
    length_d  = length_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;

    enter_rec  = (state_d == ST_RECORD) && (state_q != ST_RECORD);
    enter_play = (state_d == ST_PLAY) && (state_q != ST_PLAY);

    // advance the accumulator, then fold back at most twice since Freq < 2.0
    len_ph   = {1'b0, length_q, 7'b0};
    ph_step  = phase_q + PH_W'(Freq);
    ph_wrap1 = (ph_step >= len_ph) ? (ph_step - len_ph) : ph_step;
    ph_wrap2 = (ph_wrap1 >= len_ph) ? (ph_wrap1 - len_ph) : ph_wrap1;

    case (state_q)
      ST_RECORD: begin
        if (Sample_Tick && (length_q < DEPTH_L)) begin
          we_d     = 1'b1;
          addr_d   = length_q[ADDR_W-1:0];
          wdata_d  = Audio_In;
          length_d = length_q + 1'b1;
        end
      end
      ST_PLAY: begin
        if (Sample_Tick && (length_q != '0)) begin
          re_d    = 1'b1;
          addr_d  = phase_q[ADDR_W+6:7];
          phase_d = ph_wrap2;
        end
      end
      default: begin
      end
    endcase

    if (enter_rec) begin
      length_d = '0;
    end
    if (enter_play) begin
      phase_d = '0;
    end

    // a read whose data would land outside PLAY is dropped
    rd_pend_d = re_q && (state_d == ST_PLAY);

    if (state_d != ST_PLAY) begin
      audio_d = '0;
    end else if (rd_pend_q) begin
      audio_d = mem.Mem_RData;
    end else begin
      audio_d = audio_q;
    end
  end

  // all controller state, cleared immediately by Reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      length_q  <= '0;
      phase_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      re_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      audio_q   <= '0;
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      re_q      <= re_d;
      rd_pend_q <= rd_pend_d;
      audio_q   <= audio_d;
    end
  end

  assign mem.Mem_Addr  = addr_q;
  assign mem.Mem_WE    = we_q;
  assign mem.Mem_WData = wdata_q;
  assign mem.Mem_RE    = re_q;
  assign Audio_Out     = audio_q;
  assign Length        = length_q;
  assign Buf_Full      = (length_q == DEPTH_L);
  assign State         = state_q;

endmodule

// File: tb/tb_veritune_buf_ctrl.sv
// tb/tb_veritune_buf_ctrl.sv - testbench for veritune_buf_ctrl
module tb_veritune_buf_ctrl;
  localparam int AW = 3;
  localparam int DW = 4;
  localparam int DEPTH = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Rec_Mode = 1'b0;
  logic          Play_Mode = 1'b0;
  logic          Sample_Tick = 1'b0;
  logic [7:0]    Freq = 8'd128;
  logic [DW-1:0] Audio_In = '0;
  logic [DW-1:0] Audio_Out;
  logic [AW:0]   Length;
  logic          Buf_Full;
  logic [1:0]    State;

  veritune_buf_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

  veritune_buf_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Reset(Reset), .Rec_Mode(Rec_Mode), .Play_Mode(Play_Mode),
    .Sample_Tick(Sample_Tick), .Freq(Freq), .Audio_In(Audio_In), .mem(mem),
    .Audio_Out(Audio_Out), .Length(Length), .Buf_Full(Buf_Full), .State(State)
  );

  always #5 Clk = ~Clk;

  logic [DW-1:0] ram [DEPTH];
  always @(posedge Clk) begin
    if (mem.Mem_WE) ram[mem.Mem_Addr] <= mem.Mem_WData;
    if (mem.Mem_RE) mem.Mem_RData <= ram[mem.Mem_Addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  logic          o_we, o_re, o_full;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wd, o_out;
  logic [AW:0]   o_len;
  logic [1:0]    o_st;

  // one 3-cycle window: set modes (and optionally tick), sample strobes after the first edge, Audio_Out after the third
  task automatic step(input logic rec, input logic play, input logic tick, input logic [DW-1:0] din, input logic [7:0] f);
    @(negedge Clk);
    Rec_Mode = rec; Play_Mode = play; Sample_Tick = tick; Audio_In = din; Freq = f;
    @(posedge Clk); #1;
    o_we = mem.Mem_WE; o_re = mem.Mem_RE; o_addr = mem.Mem_Addr; o_wd = mem.Mem_WData;
    o_len = Length; o_st = State; o_full = Buf_Full;
    chk("strobe_excl", {31'd0, o_we & o_re}, 0);
    @(negedge Clk);
    Sample_Tick = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #1;
    o_out = Audio_Out;
  endtask

  typedef struct {
    logic rec, play, tick;
    logic [3:0] din;
    logic [7:0] freq;
    logic [1:0] st;
    logic we, re;
    logic [2:0] addr;
    logic [3:0] len;
    logic [3:0] aout;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(input logic rec, input logic play, input logic tick, input logic [3:0] din,
                               input logic [7:0] f, input logic [1:0] st, input logic we, input logic re,
                               input logic [2:0] addr, input logic [3:0] len, input logic [3:0] aout);
    vec_t v;
    v.rec = rec; v.play = play; v.tick = tick; v.din = din; v.freq = f; v.st = st;
    v.we = we; v.re = re; v.addr = addr; v.len = len; v.aout = aout;
    return v;
  endfunction

  logic [3:0] mdl[$];
  int rec_d[5] = '{1, 0, 1, 1, 0};
  int a128[7] = '{0, 1, 2, 3, 4, 0, 1};
  int o128[7] = '{1, 0, 1, 1, 0, 1, 0};
  int a255[7] = '{0, 1, 3, 0, 2, 4, 1};
  int a64[6]  = '{0, 0, 1, 1, 2, 2};
  int wes, n, nt, f, k, L, ph, ea;
  logic [3:0] d;
  logic full;

  initial begin
    // table: basic record, 1.0x play, HOLD/PLAY restart with fast and slow rates
    vt.push_back(mkv(1, 0, 0, 0, 128, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vt.push_back(mkv(1, 0, 1, 4'(rec_d[i]), 128, 1, 1, 0, 3'(i), 4'(i + 1), 0));
    vt.push_back(mkv(0, 1, 0, 0, 128, 3, 0, 0, 0, 5, 0));
    for (int i = 0; i < 7; i++)
      vt.push_back(mkv(0, 1, 1, 0, 128, 3, 0, 1, 3'(a128[i]), 5, 4'(o128[i])));
    vt.push_back(mkv(0, 0, 0, 0, 255, 2, 0, 0, 0, 5, 0));
    vt.push_back(mkv(0, 1, 0, 0, 255, 3, 0, 0, 0, 5, 0));
    for (int i = 0; i < 7; i++)
      vt.push_back(mkv(0, 1, 1, 0, 255, 3, 0, 1, 3'(a255[i]), 5, 4'(rec_d[a255[i]])));
    vt.push_back(mkv(0, 0, 0, 0, 64, 2, 0, 0, 0, 5, 0));
    vt.push_back(mkv(0, 1, 0, 0, 64, 3, 0, 0, 0, 5, 0));
    for (int i = 0; i < 6; i++)
      vt.push_back(mkv(0, 1, 1, 0, 64, 3, 0, 1, 3'(a64[i]), 5, 4'(rec_d[a64[i]])));
    vt.push_back(mkv(0, 0, 0, 0, 64, 2, 0, 0, 0, 5, 0));

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_state", State, 0);
    chk("rst_len", Length, 0);
    chk("rst_we", mem.Mem_WE, 0);
    chk("rst_re", mem.Mem_RE, 0);
    chk("rst_addr", mem.Mem_Addr, 0);
    chk("rst_wdata", mem.Mem_WData, 0);
    chk("rst_out", Audio_Out, 0);
    chk("rst_full", Buf_Full, 0);
    @(negedge Clk);
    Reset = 1'b0;

    foreach (vt[i]) begin
      step(vt[i].rec, vt[i].play, vt[i].tick, vt[i].din, vt[i].freq);
      chk($sformatf("tbl%0d_state", i), o_st, vt[i].st);
      chk($sformatf("tbl%0d_we", i), o_we, vt[i].we);
      chk($sformatf("tbl%0d_re", i), o_re, vt[i].re);
      if (vt[i].we | vt[i].re) chk($sformatf("tbl%0d_addr", i), o_addr, vt[i].addr);
      if (vt[i].we) chk($sformatf("tbl%0d_wdata", i), o_wd, vt[i].din);
      chk($sformatf("tbl%0d_len", i), o_len, vt[i].len);
      chk($sformatf("tbl%0d_out", i), o_out, vt[i].aout);
    end

    // buffer full: 10 ticks into an 8-deep buffer
    step(1, 0, 0, 0, 128);
    chk("full_enter_len", o_len, 0);
    wes = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, 4'(i + 3), 128);
      if (o_we) begin
        chk("full_addr", o_addr, wes);
        wes++;
      end
    end
    chk("full_we_count", wes, 8);
    chk("full_len", o_len, 8);
    chk("full_flag", o_full, 1);
    step(0, 1, 0, 0, 128);
    step(0, 0, 0, 0, 128);
    chk("full_hold_state", o_st, 2);
    step(1, 0, 0, 0, 128);
    chk("rerec_len", o_len, 0);
    chk("rerec_full", o_full, 0);

    // empty buffer playback
    step(0, 1, 0, 0, 128);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 128);
      chk("empty_re", o_re, 0);
      chk("empty_out", o_out, 0);
    end

    // single-sample buffer at the fastest rate
    step(1, 0, 0, 0, 255);
    step(1, 0, 1, 9, 255);
    step(0, 1, 0, 0, 255);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 0, 255);
      chk("len1_addr", o_addr, 0);
      chk("len1_out", o_out, 9);
    end

    // reset while a read is in flight
    @(negedge Clk);
    Sample_Tick = 1'b1;
    @(posedge Clk); #1;
    chk("midrst_re_before", mem.Mem_RE, 1);
    @(negedge Clk);
    Sample_Tick = 1'b0;
    Reset = 1'b1;
    #1;
    chk("midrst_state", State, 0);
    chk("midrst_len", Length, 0);
    chk("midrst_re", mem.Mem_RE, 0);
    chk("midrst_we", mem.Mem_WE, 0);
    chk("midrst_addr", mem.Mem_Addr, 0);
    chk("midrst_out", Audio_Out, 0);
    repeat (2) @(posedge Clk);
    #1;
    chk("midrst_out_late", Audio_Out, 0);
    @(negedge Clk);
    Reset = 1'b0; Play_Mode = 1'b0; Rec_Mode = 1'b0;
    @(posedge Clk); #1;
    chk("post_rst_idle", State, 0);

    // randomized record/play against a closed-form model of the phase walk
    for (int it = 0; it < 20; it++) begin
      step(0, 0, 0, 0, 128);
      step(1, 0, 0, 0, 128);
      chk("rnd_rec_len0", o_len, 0);
      mdl.delete();
      n = $urandom_range(0, 10);
      for (int j = 0; j < n; j++) begin
        d = 4'($urandom);
        full = (mdl.size() >= DEPTH);
        step(1, 0, 1, d, 128);
        chk("rnd_we", o_we, !full);
        if (!full) begin
          chk("rnd_waddr", o_addr, mdl.size());
          chk("rnd_wdata", o_wd, d);
          mdl.push_back(d);
        end
        chk("rnd_len", o_len, mdl.size());
      end
      case ($urandom_range(0, 3))
        0: f = 0;
        1: f = 255;
        default: f = $urandom_range(0, 255);
      endcase
      L = mdl.size();
      step(0, 1, 0, 0, 8'(f));
      chk("rnd_play_state", o_st, 3);
      k = 0;
      nt = $urandom_range(1, 12);
      for (int t = 0; t < nt; t++) begin
        if ($urandom_range(0, 5) == 0) begin
          step(0, 0, 0, 0, 8'(f));
          chk("rnd_hold_state", o_st, 2);
          chk("rnd_hold_out", o_out, 0);
          step(0, 1, 0, 0, 8'(f));
          k = 0;
        end
        step(0, 1, 1, 4'($urandom), 8'(f));
        if (L == 0) begin
          chk("rnd_empty_re", o_re, 0);
          chk("rnd_empty_out", o_out, 0);
        end else begin
          ph = (k * f) % (L * 128);
          ea = ph / 128;
          chk("rnd_re", o_re, 1);
          chk("rnd_raddr", o_addr, ea);
          chk("rnd_out", o_out, mdl[ea]);
          k++;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
